// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - load-type codes, FSM states and alignment check for the load data register
package load_pkg;

  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_FULL = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Offset arrives zero-extended to 3 bits so one function serves 32- and 64-bit buses.
  function automatic logic load_ok(input logic [2:0] lt, input logic [2:0] off);
    logic ok;
    case (lt)
      LT_LB, LT_LBU: ok = 1'b1;
      LT_LH, LT_LHU: ok = (off[0] == 1'b0);
      LT_FULL:       ok = (off == 3'b000);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - byte/halfword lane select with sign or zero extension
module load_extract
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [2:0]            load_type,
  input  logic [OFF_W-1:0]      byte_offset,
  input  logic [DATA_WIDTH-1:0] memory_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;

  assign shifted = memory_out >> {byte_offset, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];

  always_comb begin
    data_out = memory_out;
    case (load_type)
      LT_LB:   data_out = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      LT_LH:   data_out = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      LT_LBU:  data_out = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      LT_LHU:  data_out = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: data_out = memory_out;
    endcase
  end

endmodule

// File: rtl/load_data_register.sv
// rtl/load_data_register.sv - memory data register with ready handshake, extraction and error flags
module load_data_register
  import load_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int OFF_W          = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [2:0]            load_type,
  input  logic [OFF_W-1:0]      byte_offset,
  input  logic [DATA_WIDTH-1:0] memory_out,
  input  logic                  memory_ready,
  output logic [DATA_WIDTH-1:0] memory_data_register,
  output logic                  mdr_valid,
  output logic                  load_busy,
  output logic                  load_error
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [0:0]            state;
  logic [CNT_W-1:0]      counter;
  logic [CNT_W-1:0]      cnt_next;
  logic [2:0]            lt_q;
  logic [OFF_W-1:0]      off_q;
  logic [DATA_WIDTH-1:0] extracted;

  // Extraction uses the request captured at acceptance, not the live inputs.
  load_extract #(
    .DATA_WIDTH(DATA_WIDTH),
    .OFF_W     (OFF_W)
  ) u_extract (
    .load_type  (lt_q),
    .byte_offset(off_q),
    .memory_out (memory_out),
    .data_out   (extracted)
  );

  assign cnt_next  = counter + 1'b1;
  assign load_busy = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      memory_data_register <= '0;
      mdr_valid            <= 1'b0;
      load_error           <= 1'b0;
      counter              <= '0;
      lt_q                 <= LT_LB;
      off_q                <= '0;
    end else begin
      mdr_valid  <= 1'b0;
      load_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            if (load_ok(load_type, 3'(byte_offset))) begin
              lt_q    <= load_type;
              off_q   <= byte_offset;
              counter <= '0;
              state   <= ST_WAIT;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          // Ready takes priority over an expiring timeout on the same edge.
          if (memory_ready) begin
            memory_data_register <= extracted;
            mdr_valid            <= 1'b1;
            state                <= ST_IDLE;
          end else begin
            counter <= cnt_next;
            if (TO_EN && (cnt_next == CNT_W'(TIMEOUT_CYCLES))) begin
              load_error <= 1'b1;
              state      <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_data_register.sv
// tb/tb_load_data_register.sv - directed self-checking bench for load_data_register
module tb_load_data_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [2:0]  load_type;
  logic [1:0]  byte_offset;
  logic [31:0] memory_out;
  logic        memory_ready;
  logic [31:0] memory_data_register;
  logic        mdr_valid;
  logic        load_busy;
  logic        load_error;

  int vectors = 0;
  int miscompares = 0;

  load_data_register #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .load_start          (load_start),
    .load_type           (load_type),
    .byte_offset         (byte_offset),
    .memory_out          (memory_out),
    .memory_ready        (memory_ready),
    .memory_data_register(memory_data_register),
    .mdr_valid           (mdr_valid),
    .load_busy           (load_busy),
    .load_error          (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load with ready already high: accepted at E0, completes at E1.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                         input logic [31:0] data, input logic [31:0] exp);
    load_start = 1'b1; load_type = lt; byte_offset = off;
    memory_out = data; memory_ready = 1'b1;
    step();
    load_start = 1'b0;
    chk({tag, "_busy_e0"}, 64'(load_busy), 64'd1);
    chk({tag, "_valid_e0"}, 64'(mdr_valid), 64'd0);
    step();
    chk({tag, "_data"}, 64'(memory_data_register), 64'(exp));
    chk({tag, "_valid_e1"}, 64'(mdr_valid), 64'd1);
    chk({tag, "_busy_e1"}, 64'(load_busy), 64'd0);
    step();
    chk({tag, "_valid_e2"}, 64'(mdr_valid), 64'd0);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] lt, input logic [1:0] off);
    load_start = 1'b1; load_type = lt; byte_offset = off; memory_ready = 1'b1;
    step();
    load_start = 1'b0;
    chk({tag, "_err"}, 64'(load_error), 64'd1);
    chk({tag, "_busy"}, 64'(load_busy), 64'd0);
    step();
    chk({tag, "_err_clr"}, 64'(load_error), 64'd0);
    chk({tag, "_hold"}, 64'(memory_data_register), 64'h8A7BC6D5);
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_type = 3'b000; byte_offset = 2'd0;
    memory_out = 32'h8A7BC6D5; memory_ready = 1'b1;
    step(); step();
    chk("rst_data", 64'(memory_data_register), 64'd0);
    chk("rst_valid", 64'(mdr_valid), 64'd0);
    chk("rst_error", 64'(load_error), 64'd0);
    chk("rst_busy", 64'(load_busy), 64'd0);
    rst_n = 1'b1;
    step();

    do_load("lb0",   3'b000, 2'd0, 32'h8A7BC6D5, 32'hFFFFFFD5);
    do_load("lbu3",  3'b100, 2'd3, 32'h8A7BC6D5, 32'h0000008A);
    do_load("lhu2",  3'b101, 2'd2, 32'h8A7BC6D5, 32'h00008A7B);
    do_load("lh0",   3'b001, 2'd0, 32'h8A7BC6D5, 32'hFFFFC6D5);
    do_load("full0", 3'b010, 2'd0, 32'h8A7BC6D5, 32'h8A7BC6D5);

    bad_load("lh1",   3'b001, 2'd1);
    bad_load("full2", 3'b010, 2'd2);
    bad_load("lt011", 3'b011, 2'd0);

    // Timeout: 15 not-ready WAIT edges.
    load_start = 1'b1; load_type = 3'b000; byte_offset = 2'd0; memory_ready = 1'b0;
    step();
    load_start = 1'b0;
    for (int i = 1; i <= 14; i++) step();
    chk("to_busy14", 64'(load_busy), 64'd1);
    chk("to_err14", 64'(load_error), 64'd0);
    step();
    chk("to_err15", 64'(load_error), 64'd1);
    chk("to_busy15", 64'(load_busy), 64'd0);
    chk("to_valid15", 64'(mdr_valid), 64'd0);
    chk("to_hold", 64'(memory_data_register), 64'h8A7BC6D5);
    step();
    chk("to_err_clr", 64'(load_error), 64'd0);

    // Ready on the 15th edge wins over the timeout.
    load_start = 1'b1; load_type = 3'b000; byte_offset = 2'd0;
    memory_out = 32'h000000A5; memory_ready = 1'b0;
    step();
    load_start = 1'b0;
    for (int i = 1; i <= 14; i++) step();
    memory_ready = 1'b1;
    step();
    chk("rw_valid", 64'(mdr_valid), 64'd1);
    chk("rw_err", 64'(load_error), 64'd0);
    chk("rw_data", 64'(memory_data_register), 64'hFFFFFFA5);
    step();

    // Reset during the 3rd WAIT cycle.
    load_start = 1'b1; load_type = 3'b010; byte_offset = 2'd0;
    memory_out = 32'hDEADBEEF; memory_ready = 1'b0;
    step();
    load_start = 1'b0;
    step(); step();
    chk("mr_busy", 64'(load_busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; memory_ready = 1'b1;
    step();
    chk("mr_data", 64'(memory_data_register), 64'd0);
    chk("mr_valid", 64'(mdr_valid), 64'd0);
    chk("mr_busy_after", 64'(load_busy), 64'd0);
    chk("mr_err", 64'(load_error), 64'd0);

    // Back-to-back: second request accepted while mdr_valid is high.
    load_start = 1'b1; load_type = 3'b010; byte_offset = 2'd0;
    memory_out = 32'h11223344; memory_ready = 1'b1;
    step();
    load_start = 1'b0;
    chk("bb_busy1", 64'(load_busy), 64'd1);
    step();
    chk("bb_data1", 64'(memory_data_register), 64'h11223344);
    chk("bb_valid1", 64'(mdr_valid), 64'd1);
    load_start = 1'b1; load_type = 3'b100; byte_offset = 2'd1;
    step();
    load_start = 1'b0;
    chk("bb_busy2", 64'(load_busy), 64'd1);
    chk("bb_valid_gap", 64'(mdr_valid), 64'd0);
    step();
    chk("bb_data2", 64'(memory_data_register), 64'h00000033);
    chk("bb_valid2", 64'(mdr_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
